pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised pipeline-stage register that replaces the fixed-width IF/ID latch. It carries an arbitrary-width payload, such as the packed inst/pc/pc_sub4/pc_add8/pc_add4/exc/jb_delayslot bundle, between two stages.
- Uses a valid/ready handshake, with stall-hold and flush-to-bubble control.
- An optional second (skid) entry gives full throughput with a fully registered upstream ready.
- Instantiated once per stage boundary (IF/ID, ID/EX, ...).

Parameters:
W, 224, payload width in bits (default = 7 x 32 ID bundle)
SKID, 1, 1 = two-entry skid buffer with registered ready_; 0 = single entry, combinational ready_
CNT_W, 8, width of saturating flush-kill counter

Ports:
_clk  in  1  clock
_rst  in  1  asynchronous, active-low reset
_flush  in  1  discard all held and incoming beats (branch/exception)
_stall  in  1  hazard-unit hold; blocks downstream transfer
_valid  in  1  upstream beat valid
ready_  out  1  stage can accept a beat
_data  in  W  upstream payload
valid_  out  1  downstream beat valid
_ready  in  1  downstream can accept
data_  out  W  downstream payload (registered)
occ_  out  2  entries held: 0..2
flush_cnt_  out  CNT_W  count of valid entries killed by flush, saturating

Behaviour:
- Reset (_rst=0, asynchronous): main and skid entries invalid and zero.
  - valid_=0, data_=0, occ_=0, flush_cnt_=0.
  - ready_=1 once _rst deasserts.
  - Reset mid-transfer drops the beat; no partial state survives.
- Definitions:
  - acc = _valid & ready_ & !_flush.
  - xfer = valid_ & _ready & !_stall.
- valid_/data_ come straight from the main register. data_ is 0 whenever valid_=0 (bubble is all-zero, equal to NOP inst).
- Latency: an accepted beat appears on data_ on the edge after acceptance (1 cycle).
- Occupancy FSM (EMPTY, ONE, FULL), evaluated at posedge _clk:
  - EMPTY: acc -> ONE, main<=_data; else stay.
  - ONE, acc & xfer -> ONE, main<=_data.
  - ONE, acc & !xfer -> FULL, skid<=_data (only when SKID=1).
  - ONE, !acc & xfer -> EMPTY, main<=0.
  - ONE, neither -> hold.
  - FULL, xfer -> ONE, main<=skid, skid<=0.
  - FULL, !xfer -> hold.
- ready_:
  - SKID=1: registered, ready_ = (next state != FULL). It never depends combinationally on _ready/_stall.
  - SKID=0: ready_ = !valid_ | xfer (combinational). FULL is unreachable, occ_ is never 2.
- _stall:
  - Main is frozen; data_/valid_ are stable every stalled cycle.
  - Upstream may still fill the skid (SKID=1), then ready_ drops.
- _flush has the highest priority:
  - Next edge: EMPTY, main=skid=0, valid_=0, ready_=1.
  - The upstream beat offered in the flush cycle is not accepted and is lost. Upstream must treat it as killed.
  - flush_cnt_ += occ_ (0, 1 or 2), saturating at 2^CNT_W-1.
- Simultaneous flush & stall: flush wins.
- Simultaneous flush & xfer: no transfer counted; the beat is killed.
- No beat is duplicated or reordered. Beats leave in acceptance order.
- occ_ always equals the number of valid entries (main, skid).

Decomposition:
- Shared package `pipe_pkg`:
  - Field widths and bit offsets for INST, PC, PC_SUB4, PC_ADD8, PC_ADD4, EXC, JB_DELAYSLOT.
  - ID_BUNDLE_W=224.
  - Occupancy state encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- One sub-module, `pipe_stage_ctrl`: the occupancy FSM, ready_ generation and the flush counter. It outputs load_main, load_skid, main_from_skid and clear strobes.
- The top holds the W-wide datapath registers and muxes.

Test Plan:
- Reset/idle: _rst=0 for 3 cycles with _valid=1, _data=0x...ABCD → valid_=0, data_=0, occ_=0, ready_=1 after release; no beat accepted during reset.
- Streaming, SKID=1: beats 1..8, _ready=1, _stall=0 → one beat out per cycle after 1-cycle latency; data_ = 1..8 in order; occ_=1 steady.
- Stall fill: stall 3 cycles while sending 0x11, 0x22, 0x33 → data_ holds 0x11; 0x22 goes to skid; ready_=0 from cycle 2; 0x33 held upstream; after release, order 0x11, 0x22, 0x33.
- Flush in FULL: occ_=2, then _flush=1 with _valid=1, _data=0x44 → next cycle valid_=0, data_=0, occ_=0, flush_cnt_=2, and 0x44 never appears.
- Flush+stall same cycle, SKID=0: occ_=1 → flush wins, EMPTY, flush_cnt_ +1; ready_ combinational = 1 while empty; random _ready backpressure for 1000 beats with SKID=0 matches the scoreboard.
- Counter saturation, CNT_W=2: 5 flushes each killing 1 entry → flush_cnt_ sticks at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers.
//   - Field widths and bit offsets of the packed IF/ID bundle
//     {inst, pc, pc_sub4, pc_add8, pc_add4, exc, jb_delayslot}, with inst in the MSBs.
//   - Occupancy state encoding of a stage register (EMPTY/ONE/FULL).
package pipe_pkg;

  localparam int INST_W         = 32;
  localparam int PC_W           = 32;
  localparam int PC_SUB4_W      = 32;
  localparam int PC_ADD8_W      = 32;
  localparam int PC_ADD4_W      = 32;
  localparam int EXC_W          = 32;
  localparam int JB_DELAYSLOT_W = 32;

  localparam int JB_DELAYSLOT_LSB = 0;
  localparam int EXC_LSB          = JB_DELAYSLOT_LSB + JB_DELAYSLOT_W;
  localparam int PC_ADD4_LSB      = EXC_LSB + EXC_W;
  localparam int PC_ADD8_LSB      = PC_ADD4_LSB + PC_ADD4_W;
  localparam int PC_SUB4_LSB      = PC_ADD8_LSB + PC_ADD8_W;
  localparam int PC_LSB           = PC_SUB4_LSB + PC_SUB4_W;
  localparam int INST_LSB         = PC_LSB + PC_W;

  localparam int ID_BUNDLE_W = INST_LSB + INST_W;  // 224

  typedef struct packed {
    logic [INST_W-1:0]         inst;
    logic [PC_W-1:0]           pc;
    logic [PC_SUB4_W-1:0]      pc_sub4;
    logic [PC_ADD8_W-1:0]      pc_add8;
    logic [PC_ADD4_W-1:0]      pc_add4;
    logic [EXC_W-1:0]          exc;
    logic [JB_DELAYSLOT_W-1:0] jb_delayslot;
  } id_bundle_t;

  // Encoding doubles as the occupancy count driven on occ_.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle around one pipeline-stage register.
//   _valid/_data/ready_ : upstream side (producer -> stage)
//   valid_/data_/_ready : downstream side (stage -> consumer)
// Modports:
//   slave  : the stage register's view
//   master : the surrounding pipeline's view (drives upstream beats and downstream ready)
interface pipe_stage_skid_if #(
  parameter int W = pipe_pkg::ID_BUNDLE_W
);
  import pipe_pkg::*;

  logic         _valid;
  logic         ready_;
  logic [W-1:0] _data;
  logic         valid_;
  logic         _ready;
  logic [W-1:0] data_;

  modport slave (
    input  _valid, _data, _ready,
    output ready_, valid_, data_
  );

  modport master (
    output _valid, _data, _ready,
    input  ready_, valid_, data_
  );

endinterface

// File: rtl/pipe_stage_ctrl.sv
// Control half of a pipeline-stage register: occupancy FSM, upstream ready
// generation and the saturating flush-kill counter.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush, stall    : kill everything / hold downstream transfer
//   in_valid        : upstream beat valid
//   out_ready       : downstream ready
//   ready           : stage can accept (registered when SKID=1)
//   load_main       : main <= upstream data
//   load_skid       : skid <= upstream data
//   main_from_skid  : main <= skid
//   clear_main/skid : entry <= 0 (bubble)
//   occ             : number of valid entries
//   flush_cnt       : valid entries killed by flush, saturating
module pipe_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int SKID  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             ready,
  output logic             load_main,
  output logic             load_skid,
  output logic             main_from_skid,
  output logic             clear_main,
  output logic             clear_skid,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] flush_cnt
);

  occ_e             state_q, state_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_s;
  logic             xfer_s;
  logic             acc_s;

  // Add a 0..2 kill count to the counter, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W+1:0] sum;
    sum = {2'b00, a} + {{CNT_W{1'b0}}, b};
    if (sum > {2'b00, {CNT_W{1'b1}}}) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  assign valid_s = (state_q != EMPTY);
  assign xfer_s  = valid_s & out_ready & ~stall;
  // Single-entry mode can only refill in the cycle the held beat leaves.
  assign ready   = (SKID != 0) ? ready_q : (~valid_s | xfer_s);
  assign acc_s   = in_valid & ready & ~flush;
  assign occ     = state_q;
  assign flush_cnt = cnt_q;

  // Next-state, datapath strobes, next ready and flush counter.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    clear_main     = 1'b0;
    clear_skid     = 1'b0;
    if (flush) begin
      // Flush beats stall and transfer: every held entry is killed, none leaves.
      state_d    = EMPTY;
      clear_main = 1'b1;
      clear_skid = 1'b1;
      cnt_d      = sat_add(cnt_q, state_q);
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc_s) begin
            state_d   = ONE;
            load_main = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (acc_s && xfer_s) begin
            state_d   = ONE;
            load_main = 1'b1;
          end else if (acc_s && !xfer_s) begin
            // Unreachable with SKID=0: ready there implies the main entry leaves.
            if (SKID != 0) begin
              state_d   = FULL;
              load_skid = 1'b1;
            end else begin
              state_d = ONE;
            end
          end else if (xfer_s) begin
            state_d    = EMPTY;
            clear_main = 1'b1;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          if (xfer_s) begin
            state_d        = ONE;
            main_from_skid = 1'b1;
            clear_skid     = 1'b1;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d    = EMPTY;
          clear_main = 1'b1;
          clear_skid = 1'b1;
        end
      endcase
    end
    // Registered ready looks at where we are going, so it never depends on _ready/_stall.
    ready_d = (state_d != FULL);
  end

  // State, registered ready and flush counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline-stage register with valid/ready handshake, stall hold,
// flush-to-bubble and an optional skid entry.
// Ports:
//   _clk, _rst   : clock, asynchronous active-low reset
//   _flush       : discard all held and incoming beats
//   _stall       : hold the main entry, block downstream transfer
//   bus          : handshake bundle (upstream _valid/_data/ready_, downstream valid_/data_/_ready)
//   occ_         : entries held, 0..2
//   flush_cnt_   : valid entries killed by flush, saturating
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int W     = ID_BUNDLE_W,
  parameter int SKID  = 1,
  parameter int CNT_W = 8
) (
  input  logic              _clk,
  input  logic              _rst,
  input  logic              _flush,
  input  logic              _stall,
  pipe_stage_skid_if.slave  bus,
  output logic [1:0]        occ_,
  output logic [CNT_W-1:0]  flush_cnt_
);

  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         main_vld_q, main_vld_d;
  logic         ready_s;
  logic         load_main_s, load_skid_s, main_from_skid_s;
  logic         clear_main_s, clear_skid_s;

  pipe_stage_ctrl #(
    .SKID  (SKID),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk            (_clk),
    .rst_n          (_rst),
    .flush          (_flush),
    .stall          (_stall),
    .in_valid       (bus._valid),
    .out_ready      (bus._ready),
    .ready          (ready_s),
    .load_main      (load_main_s),
    .load_skid      (load_skid_s),
    .main_from_skid (main_from_skid_s),
    .clear_main     (clear_main_s),
    .clear_skid     (clear_skid_s),
    .occ            (occ_),
    .flush_cnt      (flush_cnt_)
  );

  // Main/skid entry next values; clearing wins so a bubble is always all-zero.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    if (clear_main_s) begin
      main_d     = {W{1'b0}};
      main_vld_d = 1'b0;
    end else if (load_main_s) begin
      main_d     = bus._data;
      main_vld_d = 1'b1;
    end else if (main_from_skid_s) begin
      main_d     = skid_q;
      main_vld_d = 1'b1;
    end else begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
    end
    if (clear_skid_s) begin
      skid_d = {W{1'b0}};
    end else if (load_skid_s) begin
      skid_d = bus._data;
    end else begin
      skid_d = skid_q;
    end
  end

  // Payload registers.
  always_ff @(posedge _clk or negedge _rst) begin
    if (!_rst) begin
      main_q     <= {W{1'b0}};
      main_vld_q <= 1'b0;
      skid_q     <= {W{1'b0}};
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
    end
  end

  assign bus.valid_ = main_vld_q;
  assign bus.data_  = main_q;
  assign bus.ready_ = ready_s;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: three instances
//   u1: SKID=1, CNT_W=8   (streaming, stall fill, flush in FULL, mid-transfer reset)
//   u0: SKID=0, CNT_W=8   (flush+stall, combinational ready, random backpressure)
//   u2: SKID=1, CNT_W=2   (flush counter saturation)
module tb_pipe_stage_skid;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush1, stall1, flush0, stall0, flush2, stall2;
  logic [1:0] occ1, occ0, occ2;
  logic [7:0] cnt1, cnt0;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;

  pipe_stage_skid_if #(.W(32)) if1 ();
  pipe_stage_skid_if #(.W(32)) if0 ();
  pipe_stage_skid_if #(.W(32)) if2 ();

  pipe_stage_skid #(.W(32), .SKID(1), .CNT_W(8)) u1 (
    ._clk(clk), ._rst(rst_n), ._flush(flush1), ._stall(stall1),
    .bus(if1.slave), .occ_(occ1), .flush_cnt_(cnt1));
  pipe_stage_skid #(.W(32), .SKID(0), .CNT_W(8)) u0 (
    ._clk(clk), ._rst(rst_n), ._flush(flush0), ._stall(stall0),
    .bus(if0.slave), .occ_(occ0), .flush_cnt_(cnt0));
  pipe_stage_skid #(.W(32), .SKID(1), .CNT_W(2)) u2 (
    ._clk(clk), ._rst(rst_n), ._flush(flush2), ._stall(stall2),
    .bus(if2.slave), .occ_(occ2), .flush_cnt_(cnt2));

  always #5 clk = ~clk;

  typedef struct {
    logic        f, s, v;
    logic [31:0] d;
    logic        r;
    logic        evo;
    logic [31:0] edo;
    logic        ero;
    logic [1:0]  eocc;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t t1[$];
  vec_t t0[$];

  function automatic vec_t mk(input int f, input int s, input int v, input int d, input int r,
                              input int evo, input int edo, input int ero, input int eocc,
                              input int ecnt);
    vec_t x;
    x.f = f[0]; x.s = s[0]; x.v = v[0]; x.d = d[31:0]; x.r = r[0];
    x.evo = evo[0]; x.edo = edo[31:0]; x.ero = ero[0]; x.eocc = eocc[1:0]; x.ecnt = ecnt[7:0];
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one row at the falling edge, compare the pre-edge outputs 1 time unit later.
  task automatic run_row(input int which, input int idx, input vec_t t);
    logic vo, ro;
    logic [31:0] dout;
    logic [1:0] oc;
    logic [7:0] cn;
    @(negedge clk);
    if (which == 1) begin
      flush1 = t.f; stall1 = t.s; if1._valid = t.v; if1._data = t.d; if1._ready = t.r;
    end else begin
      flush0 = t.f; stall0 = t.s; if0._valid = t.v; if0._data = t.d; if0._ready = t.r;
    end
    #1;
    if (which == 1) begin
      vo = if1.valid_; dout = if1.data_; ro = if1.ready_; oc = occ1; cn = cnt1;
    end else begin
      vo = if0.valid_; dout = if0.data_; ro = if0.ready_; oc = occ0; cn = cnt0;
    end
    chk($sformatf("t%0d[%0d].valid_", which, idx), {31'd0, vo}, {31'd0, t.evo});
    chk($sformatf("t%0d[%0d].data_", which, idx), dout, t.edo);
    chk($sformatf("t%0d[%0d].ready_", which, idx), {31'd0, ro}, {31'd0, t.ero});
    chk($sformatf("t%0d[%0d].occ_", which, idx), {30'd0, oc}, {30'd0, t.eocc});
    chk($sformatf("t%0d[%0d].flush_cnt_", which, idx), {24'd0, cn}, {24'd0, t.ecnt});
  endtask

  initial begin
    logic [31:0] sbq[$];
    logic [31:0] expd;
    int sent, recv, cyc;

    // SKID=1: streaming 1..8, stall fill, flush in FULL, flush with xfer, flush when empty
    t1.push_back(mk(0,0,1,1,1, 0,0,1,0,0));
    for (int k = 2; k <= 8; k++) t1.push_back(mk(0,0,1,k,1, 1,k-1,1,1,0));
    t1.push_back(mk(0,0,0,0,1,     1,8,1,1,0));
    t1.push_back(mk(0,0,0,0,1,     0,0,1,0,0));
    t1.push_back(mk(0,0,1,'h11,1,  0,0,1,0,0));
    t1.push_back(mk(0,1,1,'h22,1,  1,'h11,1,1,0));
    t1.push_back(mk(0,1,1,'h33,1,  1,'h11,0,2,0));
    t1.push_back(mk(0,1,1,'h33,1,  1,'h11,0,2,0));
    t1.push_back(mk(0,0,1,'h33,1,  1,'h11,0,2,0));
    t1.push_back(mk(0,0,1,'h33,1,  1,'h22,1,1,0));
    t1.push_back(mk(0,0,0,0,1,     1,'h33,1,1,0));
    t1.push_back(mk(0,0,0,0,1,     0,0,1,0,0));
    t1.push_back(mk(0,0,1,'h55,0,  0,0,1,0,0));
    t1.push_back(mk(0,0,1,'h66,0,  1,'h55,1,1,0));
    t1.push_back(mk(1,0,1,'h44,1,  1,'h55,0,2,0));
    t1.push_back(mk(0,0,1,'h77,1,  0,0,1,0,2));
    t1.push_back(mk(1,0,1,'h88,1,  1,'h77,1,1,2));
    t1.push_back(mk(1,0,0,0,1,     0,0,1,0,3));
    t1.push_back(mk(0,0,0,0,1,     0,0,1,0,3));

    // SKID=0: flush+stall with one entry, combinational ready under backpressure
    t0.push_back(mk(0,0,1,'hA1,1,  0,0,1,0,0));
    t0.push_back(mk(0,1,1,'hA2,1,  1,'hA1,0,1,0));
    t0.push_back(mk(1,1,1,'hA3,1,  1,'hA1,0,1,0));
    t0.push_back(mk(0,0,0,0,0,     0,0,1,0,1));
    t0.push_back(mk(0,0,1,'hB1,0,  0,0,1,0,1));
    t0.push_back(mk(0,0,1,'hB2,0,  1,'hB1,0,1,1));
    t0.push_back(mk(0,0,1,'hB2,1,  1,'hB1,1,1,1));
    t0.push_back(mk(0,0,0,0,1,     1,'hB2,1,1,1));
    t0.push_back(mk(0,0,0,0,0,     0,0,1,0,1));

    // Reset with an offered beat
    rst_n = 1'b0;
    flush1 = 1'b0; stall1 = 1'b0; flush0 = 1'b0; stall0 = 1'b0; flush2 = 1'b0; stall2 = 1'b0;
    if1._valid = 1'b1; if1._data = 32'h0000_ABCD; if1._ready = 1'b1;
    if0._valid = 1'b1; if0._data = 32'h0000_ABCD; if0._ready = 1'b1;
    if2._valid = 1'b1; if2._data = 32'h0000_ABCD; if2._ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst.valid_", {31'd0, if1.valid_}, 32'd0);
      chk("rst.data_", if1.data_, 32'd0);
      chk("rst.occ_", {30'd0, occ1}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    if1._valid = 1'b0; if0._valid = 1'b0; if2._valid = 1'b0;
    #1;
    chk("rel.ready1", {31'd0, if1.ready_}, 32'd1);
    chk("rel.ready0", {31'd0, if0.ready_}, 32'd1);
    chk("rel.valid1", {31'd0, if1.valid_}, 32'd0);
    chk("rel.cnt1", {24'd0, cnt1}, 32'd0);

    foreach (t1[i]) run_row(1, i, t1[i]);
    foreach (t0[i]) run_row(0, i, t0[i]);

    // SKID=0 random backpressure against a FIFO scoreboard
    sent = 0; recv = 0; cyc = 0;
    while (recv < 1000 && cyc < 20000) begin
      @(negedge clk);
      if0._valid = (sent < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      if0._data  = 32'h5A00_0000 | sent;
      if0._ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd.occ_", {30'd0, occ0}, sbq.size());
      chk("rnd.ready_", {31'd0, if0.ready_}, {31'd0, (sbq.size() == 0) | if0._ready});
      if (if0.valid_ && if0._ready) begin
        if (sbq.size() == 0) begin
          chk("rnd.unexpected_beat", if0.data_, 32'hFFFF_FFFF);
        end else begin
          expd = sbq.pop_front();
          chk("rnd.data_", if0.data_, expd);
        end
        recv++;
      end
      if (if0._valid && if0.ready_) begin
        sbq.push_back(if0._data);
        sent++;
      end
      cyc++;
    end
    chk("rnd.beats_received", recv, 32'd1000);
    if0._valid = 1'b0;

    // CNT_W=2: five flushes each killing one entry
    if2._ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if2._valid = 1'b1; if2._data = 32'h100 + k; flush2 = 1'b0;
      @(negedge clk);
      if2._valid = 1'b0; flush2 = 1'b1;
      #1;
      chk($sformatf("sat[%0d].occ_", k), {30'd0, occ2}, 32'd1);
      @(negedge clk);
      flush2 = 1'b0;
      #1;
      chk($sformatf("sat[%0d].flush_cnt_", k), {30'd0, cnt2}, (k < 3) ? k : 3);
      chk($sformatf("sat[%0d].valid_", k), {31'd0, if2.valid_}, 32'd0);
    end

    // Reset while u1 holds two beats
    @(negedge clk);
    if1._valid = 1'b1; if1._data = 32'h91; if1._ready = 1'b0;
    @(negedge clk);
    if1._data = 32'h92;
    @(negedge clk);
    if1._valid = 1'b0;
    #1;
    chk("mid.occ_before", {30'd0, occ1}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.occ_", {30'd0, occ1}, 32'd0);
    chk("mid.valid_", {31'd0, if1.valid_}, 32'd0);
    chk("mid.data_", if1.data_, 32'd0);
    chk("mid.cnt_", {24'd0, cnt1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if1._ready = 1'b1;
    @(negedge clk); #1;
    chk("mid.ready_after", {31'd0, if1.ready_}, 32'd1);
    chk("mid.valid_after", {31'd0, if1.valid_}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
